cc3000_apb_spi: RTL and testbench

APB3 completer in the fabric that answers the MSS APB master and drives the SPI link to the CC3000 Wi-Fi module. It provides control/status registers, a TX byte FIFO and an RX byte FIFO. A mode-1 byte shifter (CPOL=0, CPHA=1, MSB first) drains the TX FIFO and fills the RX FIFO. The CC3000 IRQ line is synchronised, exposed in a status bit and optionally forwarded as a fabric interrupt.

---
 rtl/cc3000_apb_spi.sv | 261 ++++++++++++++++++++++++++
 tb/tb_cc3000_apb_spi.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc3000_apb_spi.sv
// cc3000_apb_spi
//   APB3 completer that drives the SPI link to a CC3000 Wi-Fi module.
//   It holds a control register, a status register, a TX byte FIFO and an
//   RX byte FIFO. A mode-1 shifter (CPOL=0, CPHA=1, MSB first) empties the
//   TX FIFO onto the wire and fills the RX FIFO. The CC3000 IRQ line is
//   synchronised and can be forwarded as a fabric interrupt.
//
// Ports
//   FAB_CLK, FAB_RESET         clock (rising edge), synchronous active-high reset
//   PSEL/PENABLE/PWRITE/PADDR  APB3 request; only PADDR[3:2] selects a register
//   PWDATA, PRDATA             write / read data (PRDATA is 0 outside access)
//   PREADY, PSLVERR            always ready; error on bad address, TX overflow
//                              or RX underflow
//   SPI_CLK, SPI_DO, SPI_DI    SCLK, MOSI, MISO
//   SPI_CS_N                   chip select, software-controlled through CTRL.CS
//   CC_IRQ_N                   asynchronous active-low IRQ from the CC3000
//   INT                        fabric interrupt, active high
module cc3000_apb_spi #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 4
) (
  input  logic              FAB_CLK,
  input  logic              FAB_RESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              SPI_CLK,
  output logic              SPI_DO,
  input  logic              SPI_DI,
  output logic              SPI_CS_N,
  input  logic              CC_IRQ_N,
  output logic              INT
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT_HI,
    S_SHIFT_LO,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [2:0]       r_ctrl;          // {IRQ_EN, CS, EN}
  logic             r_irq_meta;
  logic             r_irq_sync;
  logic             r_int;

  logic [7:0]       r_tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_tx_wr;
  logic [PTR_W-1:0] r_tx_rd;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [7:0]       r_rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rx_wr;
  logic [PTR_W-1:0] r_rx_rd;
  logic [CNT_W-1:0] r_rx_cnt;

  logic [7:0]       r_shift;
  logic [2:0]       r_bit;
  logic [DIV_W-1:0] r_div;
  logic             r_spi_do;
  logic             r_discard;       // byte in flight was flushed; skip its RX push

  logic             w_access;
  logic             w_addr_ok;
  logic [1:0]       w_reg;
  logic             w_wr;
  logic             w_rd;
  logic             w_flush;
  logic             w_tx_full;
  logic             w_tx_empty;
  logic             w_rx_full;
  logic             w_rx_empty;
  logic             w_tx_push;
  logic             w_tx_pop;
  logic             w_rx_push;
  logic             w_rx_pop;
  logic [7:0]       w_tx_head;
  logic [7:0]       w_rx_head;
  logic [5:0]       w_status;
  logic             w_half_end;
  logic             w_spi_clk;
  logic             w_unused;

  // ---------------------------------------------------------------- APB decode
  assign w_access  = PSEL & PENABLE;
  assign w_addr_ok = ((PADDR >> 4) == '0);
  assign w_reg     = PADDR[3:2];
  assign w_wr      = w_access & w_addr_ok & PWRITE;
  assign w_rd      = w_access & w_addr_ok & ~PWRITE;
  assign w_flush   = w_wr & (w_reg == 2'd0) & PWDATA[3];
  assign w_unused  = ^{PWDATA[31:8], PADDR[1:0]};

  assign w_tx_full  = (r_tx_cnt == DEPTH_C);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == DEPTH_C);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_tx_head  = r_tx_mem[r_tx_rd];
  assign w_rx_head  = r_rx_mem[r_rx_rd];

  assign w_tx_push = w_wr & (w_reg == 2'd2) & ~w_tx_full;
  assign w_rx_pop  = w_rd & (w_reg == 2'd3) & ~w_rx_empty;
  assign w_tx_pop  = (r_state == S_LOAD);
  assign w_rx_push = (r_state == S_DONE) & ~r_discard;

  assign w_status = {r_irq_sync, (r_state != S_IDLE), w_rx_empty, w_rx_full,
                     w_tx_empty, w_tx_full};

  always_comb begin
    PRDATA  = '0;
    PSLVERR = 1'b0;
    if (w_access) begin
      if (!w_addr_ok) begin
        PSLVERR = 1'b1;
      end else begin
        case (w_reg)
          2'd0: if (!PWRITE) PRDATA = {29'b0, r_ctrl};
          2'd1: if (!PWRITE) PRDATA = {26'b0, w_status};
          2'd2: if (PWRITE && w_tx_full) PSLVERR = 1'b1;
          default: begin
            if (!PWRITE) begin
              if (w_rx_empty) PSLVERR = 1'b1;
              else            PRDATA  = {24'b0, w_rx_head};
            end
          end
        endcase
      end
    end
  end

  assign PREADY = 1'b1;

  // ---------------------------------------------------------- control + IRQ
  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      r_ctrl     <= '0;
      r_irq_meta <= 1'b0;
      r_irq_sync <= 1'b0;
      r_int      <= 1'b0;
    end else begin
      if (w_wr && (w_reg == 2'd0)) r_ctrl <= PWDATA[2:0];
      r_irq_meta <= ~CC_IRQ_N;
      r_irq_sync <= r_irq_meta;
      r_int      <= r_ctrl[2] & r_irq_sync;
    end
  end

  assign SPI_CS_N = ~r_ctrl[1];
  assign INT      = r_int;

  // ---------------------------------------------------------------- FIFOs
  // FLUSH overrides any push/pop on the same edge.
  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET || w_flush) begin
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_cnt <= '0;
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
      if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // Storage has no reset; occupancy counters alone decide validity.
  always_ff @(posedge FAB_CLK) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= PWDATA[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wr] <= r_shift;
  end

  // ---------------------------------------------------------------- shifter
  assign w_half_end = (r_div == DIV_LAST);

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) r_state <= S_IDLE;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_spi_clk    = 1'b0;
    unique case (r_state)
      // A FLUSH on this edge empties the TX FIFO, so do not start a LOAD.
      S_IDLE:     if (r_ctrl[0] && !w_tx_empty && !w_rx_full && !w_flush)
                    w_state_next = S_LOAD;
      S_LOAD:     w_state_next = S_SHIFT_HI;
      S_SHIFT_HI: begin
        w_spi_clk = 1'b1;
        if (w_half_end) w_state_next = S_SHIFT_LO;
      end
      S_SHIFT_LO: if (w_half_end)
                    w_state_next = (r_bit == 3'd0) ? S_DONE : S_SHIFT_HI;
      S_DONE:     w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      r_shift   <= '0;
      r_bit     <= '0;
      r_div     <= '0;
      r_spi_do  <= 1'b0;
      r_discard <= 1'b0;
    end else begin
      if ((r_state == S_SHIFT_HI) || (r_state == S_SHIFT_LO))
        r_div <= w_half_end ? '0 : r_div + 1'b1;
      else
        r_div <= '0;

      case (r_state)
        S_LOAD: begin
          r_shift  <= w_tx_head;
          r_bit    <= 3'd7;
          r_spi_do <= w_tx_head[7];      // MOSI valid on entry to the first SHIFT_HI
        end
        S_SHIFT_HI: if (w_half_end) r_shift <= {r_shift[6:0], SPI_DI};  // falling SCLK
        S_SHIFT_LO: if (w_half_end && (r_bit != 3'd0)) begin
          r_bit    <= r_bit - 1'b1;
          r_spi_do <= r_shift[7];
        end
        default: ;
      endcase

      if (r_state == S_IDLE) r_discard <= 1'b0;
      else if (w_flush)      r_discard <= 1'b1;
    end
  end

  assign SPI_CLK = w_spi_clk;
  assign SPI_DO  = r_spi_do;

endmodule

// File: tb/tb_cc3000_apb_spi.sv
// Testbench for cc3000_apb_spi: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a timeline model.
module tb_cc3000_apb_spi;
  localparam int CD = 4;
  localparam int D  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = 8'h00;
  logic [31:0] pwdata = 32'h0;
  logic [31:0] prdata;
  logic        pready, pslverr, sclk, sdo, scs_n, irq_int;
  logic        loop = 1'b0, rand_di = 1'b0, irq_n = 1'b1;
  logic        sdi;

  assign sdi = loop ? sdo : rand_di;

  always #5 clk = ~clk;

  cc3000_apb_spi #(.ADDR_W(8), .FIFO_DEPTH(D), .CLK_DIV(CD)) dut (
    .FAB_CLK(clk), .FAB_RESET(rst),
    .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata),
    .PREADY(pready), .PSLVERR(pslverr),
    .SPI_CLK(sclk), .SPI_DO(sdo), .SPI_DI(sdi), .SPI_CS_N(scs_n),
    .CC_IRQ_N(irq_n), .INT(irq_int)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (!loop) rand_di = 1'($urandom_range(0, 1));
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
    end
  endfunction

  // SCLK edge log (cycle stamps and MOSI at each rising edge)
  int         rise_t[$];
  int         fall_t[$];
  logic       mosi_q[$];
  logic       prev_sclk = 1'b0;
  always @(negedge clk) begin
    if (sclk === 1'b1 && prev_sclk === 1'b0) begin
      rise_t.push_back(cyc);
      mosi_q.push_back(sdo);
    end
    if (sclk === 1'b0 && prev_sclk === 1'b1) fall_t.push_back(cyc);
    prev_sclk = sclk;
  end

  // ------------------------------------------------------------ reference model
  // A byte is a timeline of 16*CD+2 cycles counted from its LOAD cycle (k=0):
  // k in 1..16*CD are the SCLK half periods, k=16*CD+1 is the RX push cycle.
  logic [7:0] tq[$];
  logic [7:0] rq[$];
  bit         m_valid = 0;
  bit         m_en, m_cs, m_ien, m_busy, m_disc, m_mosi, m_s1, m_s2, m_int;
  int         m_k;
  logic [7:0] m_cur, m_rx;

  always @(negedge clk) begin : model
    logic acc, bad, fl, txp, rxp, txpop, rxpush, eerr, esclk;
    logic [1:0]  idx;
    logic [31:0] erd;
    logic [5:0]  st;
    int nk, j;
    acc = psel && penable;
    bad = (paddr[7:4] != 4'h0);
    idx = paddr[3:2];
    if (m_valid) begin
      st = {m_s2, m_busy, rq.size() == 0, rq.size() == D, tq.size() == 0, tq.size() == D};
      erd = 32'h0;
      eerr = 1'b0;
      if (acc) begin
        if (bad) eerr = 1'b1;
        else case (idx)
          2'd0: if (!pwrite) erd = {29'b0, m_ien, m_cs, m_en};
          2'd1: if (!pwrite) erd = {26'b0, st};
          2'd2: if (pwrite && tq.size() == D) eerr = 1'b1;
          default: if (!pwrite) begin
            if (rq.size() == 0) eerr = 1'b1;
            else erd = {24'b0, rq[0]};
          end
        endcase
      end
      esclk = m_busy && m_k >= 1 && m_k <= 16*CD && (((m_k - 1) / CD) % 2 == 0);
      chk("PRDATA", prdata, erd);
      chk("PSLVERR", pslverr, eerr);
      chk("PREADY", pready, 1);
      chk("SPI_CLK", sclk, esclk);
      chk("SPI_DO", sdo, m_mosi);
      chk("SPI_CS_N", scs_n, !m_cs);
      chk("INT", irq_int, m_int);
    end
    if (rst) begin
      tq.delete(); rq.delete();
      m_en = 0; m_cs = 0; m_ien = 0; m_busy = 0; m_disc = 0; m_mosi = 0;
      m_s1 = 0; m_s2 = 0; m_int = 0; m_k = 0; m_cur = 0; m_rx = 0;
      m_valid = 1;
    end else if (m_valid) begin
      fl  = acc && !bad && pwrite && idx == 2'd0 && pwdata[3];
      txp = acc && !bad && pwrite && idx == 2'd2 && tq.size() < D;
      rxp = acc && !bad && !pwrite && idx == 2'd3 && rq.size() > 0;
      txpop = 0; rxpush = 0;
      m_int = m_ien & m_s2;
      m_s2  = m_s1;
      m_s1  = !irq_n;
      if (m_busy) begin
        if (m_k == 0) begin
          m_cur = (tq.size() > 0) ? tq[0] : 8'h00;
          txpop = 1;
        end
        nk = m_k + 1;
        if (nk <= 16*CD) begin
          j = nk - 1;
          if (j % (2*CD) == 0)  m_mosi = m_cur[7 - j / (2*CD)];
          if (j % (2*CD) == CD) m_rx = {m_rx[6:0], sdi};
        end
        if (fl) m_disc = 1;
        if (m_k == 16*CD + 1) begin
          rxpush = !m_disc;
          m_busy = 0;
        end
        m_k = nk;
      end else if (m_en && tq.size() > 0 && rq.size() < D && !fl) begin
        m_busy = 1; m_k = 0; m_disc = 0; m_rx = 0;
      end
      if (fl) begin
        tq.delete(); rq.delete();
      end else begin
        if (txpop)  void'(tq.pop_front());
        if (txp)    tq.push_back(pwdata[7:0]);
        if (rxp)    void'(rq.pop_front());
        if (rxpush) rq.push_back(m_rx);
      end
      if (acc && !bad && pwrite && idx == 2'd0) begin
        m_en = pwdata[0]; m_cs = pwdata[1]; m_ien = pwdata[2];
      end
    end
  end

  // ------------------------------------------------------------ APB driver
  // Called just after a rising edge; returns just after the access edge.
  task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err, output int t);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    rd = prdata; err = pslverr; t = cyc + 1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          t, t0, base, n;
  logic [7:0]  b;

  initial begin
    #800000;
    $display("FAIL watchdog at cycle %0d: got timeout, want finish", cyc);
    $fatal(1, "simulation timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    apb(0, 8'h04, 0, rd, err, t); chk("reset_status", rd, 32'h0A);
    apb(0, 8'h00, 0, rd, err, t); chk("reset_ctrl", rd, 32'h0);
    chk("reset_cs_n", scs_n, 1);
    chk("reset_sclk", sclk, 0);

    // Single byte 0xA5 in loopback
    loop = 1'b1;
    apb(1, 8'h00, 32'h3, rd, err, t);
    base = rise_t.size();
    apb(1, 8'h08, 32'hA5, rd, err, t0);
    repeat (16*CD + 8) @(posedge clk);
    #1;
    chk("a5_rises", rise_t.size() - base, 8);
    if (rise_t.size() >= base + 8 && fall_t.size() >= base + 8) begin
      chk("a5_first_rise", rise_t[base], t0 + 2);
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (i > 0) chk("a5_period", rise_t[base + i] - rise_t[base + i - 1], 2*CD);
        chk("a5_high", fall_t[base + i] - rise_t[base + i], CD);
        b = {b[6:0], mosi_q[base + i]};
      end
      chk("a5_mosi", b, 8'hA5);
    end
    apb(0, 8'h0C, 0, rd, err, t);
    chk("a5_rxdata", rd, 32'hA5);
    chk("a5_rx_err", err, 0);
    $display("byte A5: access edge %0d, RX read at edge %0d", t0, t);

    // Fill TX with EN=0, then drain into a full RX FIFO
    apb(1, 8'h00, 32'h0, rd, err, t);
    for (int i = 0; i < 5; i++) begin
      apb(1, 8'h08, 32'h11 * (i + 1), rd, err, t);
      chk(i == 4 ? "tx_overflow_err" : "tx_push_err", err, (i == 4) ? 1 : 0);
    end
    apb(0, 8'h04, 0, rd, err, t); chk("tx_full_flag", rd[0], 1);
    apb(1, 8'h00, 32'h1, rd, err, t);
    for (n = 0; n < 300; n++) begin
      apb(0, 8'h04, 0, rd, err, t);
      if (!rd[4] && rd[1]) break;
    end
    chk("drain_status", rd, 32'h06);
    for (int i = 0; i < 4; i++) begin
      apb(0, 8'h0C, 0, rd, err, t);
      chk("drain_rx", rd, 32'h11 * (i + 1));
    end

    // Error responses
    apb(0, 8'h0C, 0, rd, err, t); chk("rx_empty_data", rd, 0); chk("rx_empty_err", err, 1);
    apb(0, 8'h10, 0, rd, err, t); chk("bad_addr_rd_err", err, 1);
    apb(1, 8'h10, 32'h7, rd, err, t); chk("bad_addr_wr_err", err, 1);
    apb(0, 8'h00, 0, rd, err, t); chk("bad_addr_no_effect", rd, 32'h1);

    // IRQ path
    apb(1, 8'h00, 32'h4, rd, err, t);
    irq_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("int_before", irq_int, 0);
    @(posedge clk);
    #1 chk("int_set", irq_int, 1);
    apb(0, 8'h04, 0, rd, err, t); chk("status_irq", rd[5], 1);
    apb(1, 8'h00, 32'h0, rd, err, t);
    chk("int_hold", irq_int, 1);
    @(posedge clk);
    #1 chk("int_clear", irq_int, 0);
    irq_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // FLUSH while the first of three bytes is on the wire
    apb(1, 8'h00, 32'h2, rd, err, t);
    apb(1, 8'h08, 32'hC3, rd, err, t);
    apb(1, 8'h08, 32'h3C, rd, err, t);
    apb(1, 8'h08, 32'h96, rd, err, t);
    base = rise_t.size();
    apb(1, 8'h00, 32'h3, rd, err, t);
    for (n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (sclk) break;
    end
    chk("flush_sclk_seen", sclk, 1);
    apb(1, 8'h00, 32'hB, rd, err, t);
    for (n = 0; n < 300; n++) begin
      apb(0, 8'h04, 0, rd, err, t);
      if (!rd[4]) break;
    end
    chk("flush_status", rd, 32'h0A);
    chk("flush_rises", rise_t.size() - base, 8);
    apb(0, 8'h00, 0, rd, err, t); chk("flush_ctrl_rd", rd, 32'h3);

    // Randomized traffic
    loop = 1'b0;
    apb(1, 8'h00, 32'h7, rd, err, t);
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [3:0] hi, lo;
      logic [31:0] w;
      r  = $urandom_range(0, 99);
      lo = 4'($urandom_range(0, 15));
      hi = 4'($urandom_range(1, 15));
      w  = $urandom;
      if (r < 30)      apb(1, {4'h0, 2'd2, lo[1:0]}, w, rd, err, t);
      else if (r < 50) apb(0, {4'h0, 2'd3, lo[1:0]}, 0, rd, err, t);
      else if (r < 58) apb(0, {4'h0, 2'd1, lo[1:0]}, 0, rd, err, t);
      else if (r < 66) begin
        w = {28'h0, ($urandom_range(0, 5) == 0), w[2:1], ($urandom_range(0, 3) != 0)};
        apb(1, {4'h0, 2'd0, lo[1:0]}, w, rd, err, t);
      end
      else if (r < 70) apb(0, {4'h0, 2'd0, lo[1:0]}, 0, rd, err, t);
      else if (r < 74) apb(w[0], {hi, lo}, w, rd, err, t);
      else if (r < 78) begin
        case (w[1:0])
          2'd0:    apb(1, 8'h04, w, rd, err, t);
          2'd1:    apb(1, 8'h0C, w, rd, err, t);
          default: apb(0, 8'h08, 0, rd, err, t);
        endcase
      end
      else if (r < 84) irq_n = ~irq_n;
      else if (r < 98) begin
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #1;
      end
      else begin
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        apb(1, 8'h00, 32'h7, rd, err, t);
      end
    end
    repeat (4) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
